// File: rtl/mfp_ahb_lite_master.sv
// AHB-Lite initiator: valid/ready commands become SINGLE transfers, with address and data phases overlapped.
// Optional build macro MFP_AHB_MASTER_ALIGN_CHECK_EN turns misaligned commands into local-error phantoms.
module mfp_ahb_lite_master (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [1:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  output logic [2:0]  HBURST,
  output logic        HMASTLOCK,
  output logic [3:0]  HPROT,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  function automatic logic [2:0] map_size(input logic [1:0] size);
    return (size == 2'd3) ? 3'b010 : {1'b0, size};
  endfunction

  function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] data);
    case (size)
      2'd0:    return {4{data[7:0]}};
      2'd1:    return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

  // Address slot
  logic [1:0]  htrans_p0;
  logic [31:0] haddr_p0;
  logic        hwrite_p0;
  logic [2:0]  hsize_p0;
  logic [31:0] wdata_p0;
  // Data slot
  logic        vld_p1;
  logic        write_p1;
  logic [31:0] hwdata_p1;
  // Response
  logic        vld_p2;
  logic        err_p2;
  logic [31:0] rdata_p2;

  logic        err_p0;
  logic        err_p1;
  logic        ld_err;
  logic        dp_done;

`ifdef MFP_AHB_MASTER_ALIGN_CHECK_EN
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lsb);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return lsb[0];
      default: return lsb != 2'b00;
    endcase
  endfunction

  assign ld_err = misaligned(cmd_size, cmd_addr[1:0]);

  // Phantom bit travels through both slots alongside the real transfer state
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      err_p0 <= 1'b0;
      err_p1 <= 1'b0;
    end else if (HREADY) begin
      err_p1 <= err_p0;
      err_p0 <= cmd_valid && ld_err;
    end
  end
`else
  assign ld_err = 1'b0;
  assign err_p0 = 1'b0;
  assign err_p1 = 1'b0;
`endif

  assign cmd_ready = HREADY;
  assign dp_done   = vld_p1 && HREADY;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      htrans_p0 <= TRANS_IDLE;
      haddr_p0  <= '0;
      hwrite_p0 <= 1'b0;
      hsize_p0  <= '0;
      wdata_p0  <= '0;
      vld_p1    <= 1'b0;
      write_p1  <= 1'b0;
      hwdata_p1 <= '0;
      vld_p2    <= 1'b0;
      err_p2    <= 1'b0;
      rdata_p2  <= '0;
    end else begin
      // Address slot -> data slot, and new command into address slot
      if (HREADY) begin
        vld_p1    <= (htrans_p0 == TRANS_NONSEQ) || err_p0;
        write_p1  <= hwrite_p0;
        hwdata_p1 <= wdata_p0;
        if (cmd_valid) begin
          htrans_p0 <= ld_err ? TRANS_IDLE : TRANS_NONSEQ;
          haddr_p0  <= cmd_addr;
          hwrite_p0 <= cmd_write;
          hsize_p0  <= map_size(cmd_size);
          wdata_p0  <= replicate(cmd_size, cmd_wdata);
        end else begin
          htrans_p0 <= TRANS_IDLE;
        end
      end
      // Data phase completion -> response
      vld_p2 <= dp_done;
      if (dp_done) begin
        err_p2   <= HRESP | err_p1;
        rdata_p2 <= (write_p1 || err_p1) ? 32'h0 : HRDATA;
      end
    end
  end

  assign HTRANS    = htrans_p0;
  assign HADDR     = haddr_p0;
  assign HWRITE    = hwrite_p0;
  assign HSIZE     = hsize_p0;
  assign HWDATA    = hwdata_p1;
  assign HBURST    = 3'b000;
  assign HMASTLOCK = 1'b0;
  assign HPROT     = 4'b0011;
  assign rsp_valid = vld_p2;
  assign rsp_err   = err_p2;
  assign rsp_rdata = rdata_p2;

endmodule

// File: tb/tb_mfp_ahb_lite_master.sv
// Scenario bench for mfp_ahb_lite_master; responses are scored against an expected-response queue.
module tb_mfp_ahb_lite_master;
  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [1:0]  cmd_size;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HMASTLOCK, HREADY, HRESP;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;

  int checks = 0;
  int failures = 0;
  logic [32:0] exp_q[$];
  logic [32:0] mon_exp;

  mfp_ahb_lite_master dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HWDATA(HWDATA), .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HPROT(HPROT),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Scoreboard: every response pulse must match the oldest expected entry
  always @(negedge HCLK) begin
    if (rsp_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rsp_unexpected: got err=%0b rdata=%h, no response expected", rsp_err, rsp_rdata);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({rsp_err, rsp_rdata} !== mon_exp) begin
          failures++;
          $display("FAIL rsp_data: got err=%0b rdata=%h, expected err=%0b rdata=%h",
                   rsp_err, rsp_rdata, mon_exp[32], mon_exp[31:0]);
        end
      end
    end
  end

  task automatic tick();
    @(negedge HCLK);
  endtask

  task automatic drive_cmd(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                           input logic [31:0] wdata);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_size  = size;
    cmd_wdata = wdata;
  endtask

  task automatic test_reset();
    HRESET = 1'b1;
    tick();
    tick();
    checks++;
    if ({HTRANS, HADDR, HWRITE, HSIZE, HWDATA} !== '0) begin
      failures++;
      $display("FAIL reset_bus: got htrans=%h haddr=%h hwrite=%0b hsize=%h hwdata=%h, expected all 0",
               HTRANS, HADDR, HWRITE, HSIZE, HWDATA);
    end
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== '0) begin
      failures++;
      $display("FAIL reset_rsp: got valid=%0b err=%0b rdata=%h, expected 0", rsp_valid, rsp_err, rsp_rdata);
    end
    checks++;
    if ({HBURST, HMASTLOCK, HPROT} !== {3'b000, 1'b0, 4'b0011}) begin
      failures++;
      $display("FAIL reset_const: got hburst=%h hmastlock=%0b hprot=%h, expected 0 0 3", HBURST, HMASTLOCK, HPROT);
    end
    HRESET = 1'b0;
    tick();
    checks++;
    if (HTRANS !== 2'b00 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL idle_after_reset: got htrans=%h cmd_ready=%0b, expected 0 1", HTRANS, cmd_ready);
    end
  endtask

  task automatic test_single_read();
    drive_cmd(1'b0, 32'h100, 2'd2, 32'h0);
    exp_q.push_back({1'b0, 32'hDEADBEEF});
    tick();
    cmd_valid = 1'b0;
    checks++;
    if ({HTRANS, HADDR, HWRITE, HSIZE} !== {2'b10, 32'h100, 1'b0, 3'b010}) begin
      failures++;
      $display("FAIL read_addr_phase: got htrans=%h haddr=%h hwrite=%0b hsize=%h, expected 2 100 0 2",
               HTRANS, HADDR, HWRITE, HSIZE);
    end
    tick();
    HRDATA = 32'hDEADBEEF;
    checks++;
    if (HTRANS !== 2'b00) begin
      failures++;
      $display("FAIL read_nonseq_once: got htrans=%h, expected 0", HTRANS);
    end
    tick();
    HRDATA = 32'h0;
    checks++;
    if (rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL read_latency: got rsp_valid=%0b three cycles after accept, expected 1", rsp_valid);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL read_pulse: got rsp_valid=%0b, expected 0", rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    drive_cmd(1'b1, 32'h203, 2'd0, 32'h000000A5);
    exp_q.push_back({1'b0, 32'h0});
    tick();
    checks++;
    if ({HTRANS, HADDR, HWRITE, HSIZE} !== {2'b10, 32'h203, 1'b1, 3'b000}) begin
      failures++;
      $display("FAIL b2b_write_addr: got htrans=%h haddr=%h hwrite=%0b hsize=%h, expected 2 203 1 0",
               HTRANS, HADDR, HWRITE, HSIZE);
    end
    drive_cmd(1'b0, 32'h300, 2'd3, 32'h0);
    exp_q.push_back({1'b0, 32'h12345678});
    tick();
    cmd_valid = 1'b0;
    HRDATA = 32'hFFFFFFFF;
    checks++;
    if (HWDATA !== 32'hA5A5A5A5) begin
      failures++;
      $display("FAIL b2b_hwdata: got %h, expected a5a5a5a5", HWDATA);
    end
    checks++;
    if ({HTRANS, HADDR, HWRITE, HSIZE} !== {2'b10, 32'h300, 1'b0, 3'b010}) begin
      failures++;
      $display("FAIL b2b_read_addr: got htrans=%h haddr=%h hwrite=%0b hsize=%h, expected 2 300 0 2",
               HTRANS, HADDR, HWRITE, HSIZE);
    end
    tick();
    HRDATA = 32'h12345678;
    checks++;
    if (rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL b2b_rsp1: got rsp_valid=%0b, expected 1", rsp_valid);
    end
    tick();
    HRDATA = 32'h0;
    checks++;
    if (rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL b2b_rsp2: got rsp_valid=%0b, expected 1", rsp_valid);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle: got rsp_valid=%0b, expected 0", rsp_valid);
    end
  endtask

  task automatic test_half_write();
    drive_cmd(1'b1, 32'h702, 2'd1, 32'h1234BEEF);
    exp_q.push_back({1'b0, 32'h0});
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (HSIZE !== 3'b001) begin
      failures++;
      $display("FAIL half_hsize: got %h, expected 1", HSIZE);
    end
    tick();
    checks++;
    if (HWDATA !== 32'hBEEFBEEF) begin
      failures++;
      $display("FAIL half_hwdata: got %h, expected beefbeef", HWDATA);
    end
    tick();
    tick();
  endtask

  task automatic test_wait_states();
    drive_cmd(1'b1, 32'h400, 2'd2, 32'h11223344);
    exp_q.push_back({1'b0, 32'h0});
    tick();
    drive_cmd(1'b0, 32'h404, 2'd2, 32'h0);
    exp_q.push_back({1'b0, 32'hCAFEF00D});
    tick();
    cmd_valid = 1'b0;
    HREADY = 1'b0;
    for (int w = 0; w < 2; w++) begin
      tick();
      if (w == 1) HREADY = 1'b1;
      checks++;
      if ({HWDATA, HADDR, HTRANS} !== {32'h11223344, 32'h404, 2'b10}) begin
        failures++;
        $display("FAIL wait_stable_%0d: got hwdata=%h haddr=%h htrans=%h, expected 11223344 404 2",
                 w, HWDATA, HADDR, HTRANS);
      end
      checks++;
      if (rsp_valid !== 1'b0) begin
        failures++;
        $display("FAIL wait_no_rsp_%0d: got rsp_valid=%0b, expected 0", w, rsp_valid);
      end
      if (w == 0) begin
        checks++;
        if (cmd_ready !== 1'b0) begin
          failures++;
          $display("FAIL wait_cmd_ready: got %0b, expected 0", cmd_ready);
        end
      end
    end
    tick();
    HRDATA = 32'hCAFEF00D;
    checks++;
    if (rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL wait_rsp1: got rsp_valid=%0b, expected 1", rsp_valid);
    end
    tick();
    HRDATA = 32'h0;
    checks++;
    if (rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL wait_rsp2: got rsp_valid=%0b, expected 1", rsp_valid);
    end
    tick();
  endtask

  task automatic test_error();
    drive_cmd(1'b0, 32'h500, 2'd2, 32'h0);
    exp_q.push_back({1'b1, 32'h0});
    tick();
    drive_cmd(1'b0, 32'h504, 2'd2, 32'h0);
    exp_q.push_back({1'b0, 32'h0BADF00D});
    tick();
    cmd_valid = 1'b0;
    HREADY = 1'b0;
    HRESP = 1'b1;
    tick();
    HREADY = 1'b1;
    checks++;
    if (rsp_valid !== 1'b0 || HTRANS !== 2'b10 || HADDR !== 32'h504) begin
      failures++;
      $display("FAIL err_first_cycle: got rsp_valid=%0b htrans=%h haddr=%h, expected 0 2 504",
               rsp_valid, HTRANS, HADDR);
    end
    tick();
    HRESP = 1'b0;
    HRDATA = 32'h0BADF00D;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin
      failures++;
      $display("FAIL err_rsp: got rsp_valid=%0b rsp_err=%0b, expected 1 1", rsp_valid, rsp_err);
    end
    tick();
    HRDATA = 32'h0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL err_next_ok: got rsp_valid=%0b rsp_err=%0b, expected 1 0", rsp_valid, rsp_err);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    drive_cmd(1'b1, 32'h600, 2'd2, 32'h00000055);
    tick();
    cmd_valid = 1'b0;
    tick();
    checks++;
    if (HWDATA !== 32'h00000055) begin
      failures++;
      $display("FAIL rstmid_hwdata: got %h, expected 00000055", HWDATA);
    end
    HRESET = 1'b1;
    tick();
    HRESET = 1'b0;
    checks++;
    if ({HTRANS, HADDR, HWRITE, HSIZE, HWDATA, rsp_valid, rsp_err, rsp_rdata} !== '0) begin
      failures++;
      $display("FAIL rstmid_outputs: got haddr=%h hwdata=%h hsize=%h rsp_valid=%0b, expected all 0",
               HADDR, HWDATA, HSIZE, rsp_valid);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (rsp_valid !== 1'b0) begin
        failures++;
        $display("FAIL rstmid_no_rsp_%0d: got rsp_valid=%0b, expected 0", i, rsp_valid);
      end
    end
  endtask

  task automatic test_align();
    drive_cmd(1'b0, 32'h102, 2'd2, 32'h0);
`ifdef MFP_AHB_MASTER_ALIGN_CHECK_EN
    exp_q.push_back({1'b1, 32'h0});
    tick();
    cmd_valid = 1'b0;
    HRDATA = 32'hFFFFFFFF;
    checks++;
    if (HTRANS !== 2'b00) begin
      failures++;
      $display("FAIL align_idle: got htrans=%h, expected 0", HTRANS);
    end
    tick();
    tick();
    HRDATA = 32'h0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin
      failures++;
      $display("FAIL align_rsp: got rsp_valid=%0b rsp_err=%0b, expected 1 1", rsp_valid, rsp_err);
    end
`else
    exp_q.push_back({1'b0, 32'h00C0FFEE});
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (HTRANS !== 2'b10 || HADDR !== 32'h102) begin
      failures++;
      $display("FAIL misaligned_issued: got htrans=%h haddr=%h, expected 2 102", HTRANS, HADDR);
    end
    tick();
    HRDATA = 32'h00C0FFEE;
    tick();
    HRDATA = 32'h0;
    checks++;
    if (rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL misaligned_rsp: got rsp_valid=%0b, expected 1", rsp_valid);
    end
`endif
    tick();
  endtask

  initial begin
    HRESET = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr = '0;
    cmd_size = '0;
    cmd_wdata = '0;
    HRDATA = '0;
    HREADY = 1'b1;
    HRESP = 1'b0;
    test_reset();
    test_single_read();
    test_back_to_back();
    test_half_write();
    test_wait_states();
    test_error();
    test_reset_mid();
    test_align();
    tick();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_rsp: got %0d responses outstanding, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
